// File: rtl/leaf_rule_match.sv
// Leaf rule matcher: two independent 3-stage lanes that compare a packet header
// against the rule fetched from a 2-cycle-latency rule memory.

module leaf_rule_match_lane #(
  parameter int PACKET_WIDTH = 104,
  parameter int NODE_WIDTH   = 40,
  parameter int LEAF_ADDR    = 12,
  parameter int RULE_ID      = 14,
  parameter int RULE_WIDTH   = 160
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [PACKET_WIDTH-1:0] packet_i,
  input  logic                    valid_i,
  input  logic [NODE_WIDTH-1:0]   node_i,
  input  logic                    matched_i,
  output logic [LEAF_ADDR-1:0]    rule_addr_o,
  input  logic [RULE_WIDTH-1:0]   rule_data_i,
  output logic                    valid_o,
  output logic                    hit_o,
  output logic [RULE_ID-1:0]      rule_id_o,
  output logic [15:0]             hit_cnt_o
);

  logic [PACKET_WIDTH-1:0] pkt_s1_q, pkt_s2_q;
  logic [RULE_ID-1:0]      id_s1_q, id_s2_q;
  logic                    vld_s1_q, vld_s2_q;
  logic                    mat_s1_q, mat_s2_q;
  logic                    valid_q, hit_q;
  logic [RULE_ID-1:0]      rule_id_q;
  logic [15:0]             hit_cnt_q;

  logic                    valid_d, hit_d, match_d;
  logic [RULE_ID-1:0]      rule_id_d, id_in;
  logic [15:0]             hit_cnt_d;

  logic [31:0] pkt_src_ip, pkt_dst_ip, rule_src_ip, rule_dst_ip;
  logic [15:0] pkt_src_port, pkt_dst_port;
  logic [15:0] src_port_lo, src_port_hi, dst_port_lo, dst_port_hi;
  logic [7:0]  pkt_proto, rule_proto;
  logic [5:0]  src_len, dst_len;
  logic        proto_wild;
  logic        unused_bits;

  // The rule memory sees the address immediately; its data returns two cycles later.
  assign rule_addr_o = node_i[NODE_WIDTH-1 -: LEAF_ADDR];
  assign id_in       = node_i[NODE_WIDTH-LEAF_ADDR-1 -: RULE_ID];
  assign unused_bits = ^{node_i[NODE_WIDTH-LEAF_ADDR-RULE_ID-1:0], rule_data_i[10:0]};

  assign pkt_src_ip   = pkt_s2_q[103:72];
  assign pkt_dst_ip   = pkt_s2_q[71:40];
  assign pkt_src_port = pkt_s2_q[39:24];
  assign pkt_dst_port = pkt_s2_q[23:8];
  assign pkt_proto    = pkt_s2_q[7:0];

  assign rule_src_ip = rule_data_i[159:128];
  assign src_len     = rule_data_i[127:122];
  assign rule_dst_ip = rule_data_i[121:90];
  assign dst_len     = rule_data_i[89:84];
  assign src_port_lo = rule_data_i[83:68];
  assign src_port_hi = rule_data_i[67:52];
  assign dst_port_lo = rule_data_i[51:36];
  assign dst_port_hi = rule_data_i[35:20];
  assign rule_proto  = rule_data_i[19:12];
  assign proto_wild  = rule_data_i[11];

  function automatic logic prefix_ok(input logic [31:0] ip, input logic [31:0] rule_ip,
                                     input logic [5:0] len);
    logic [31:0] mask;
    if (len == 6'd0)        mask = '0;
    else if (len >= 6'd32)  mask = '1;
    else                    mask = ~(32'hFFFF_FFFF >> len);
    return ((ip ^ rule_ip) & mask) == 32'd0;
  endfunction

  // An inverted range (lo > hi) can never satisfy both bounds.
  function automatic logic port_ok(input logic [15:0] port, input logic [15:0] lo,
                                   input logic [15:0] hi);
    return (port >= lo) && (port <= hi);
  endfunction

  always_comb begin
    match_d = prefix_ok(pkt_src_ip, rule_src_ip, src_len)
           && prefix_ok(pkt_dst_ip, rule_dst_ip, dst_len)
           && port_ok(pkt_src_port, src_port_lo, src_port_hi)
           && port_ok(pkt_dst_port, dst_port_lo, dst_port_hi)
           && (proto_wild || (pkt_proto == rule_proto));
    valid_d   = vld_s2_q;
    hit_d     = vld_s2_q && mat_s2_q && match_d;
    rule_id_d = hit_d ? id_s2_q : '0;
    hit_cnt_d = hit_cnt_q;
    if (hit_d && (hit_cnt_q != 16'hFFFF)) hit_cnt_d = hit_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_s1_q  <= 1'b0;
      vld_s2_q  <= 1'b0;
      mat_s1_q  <= 1'b0;
      mat_s2_q  <= 1'b0;
      valid_q   <= 1'b0;
      hit_q     <= 1'b0;
      rule_id_q <= '0;
      hit_cnt_q <= 16'd0;
    end else begin
      vld_s1_q  <= valid_i;
      vld_s2_q  <= vld_s1_q;
      mat_s1_q  <= matched_i;
      mat_s2_q  <= mat_s1_q;
      valid_q   <= valid_d;
      hit_q     <= hit_d;
      rule_id_q <= rule_id_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  // Payload pipeline is qualified by the valid bits, so it needs no reset.
  always_ff @(posedge clk_i) begin
    pkt_s1_q <= packet_i;
    pkt_s2_q <= pkt_s1_q;
    id_s1_q  <= id_in;
    id_s2_q  <= id_s1_q;
  end

  assign valid_o   = valid_q;
  assign hit_o     = hit_q;
  assign rule_id_o = rule_id_q;
  assign hit_cnt_o = hit_cnt_q;

endmodule

module leaf_rule_match #(
  parameter int PACKET_WIDTH = 104,
  parameter int NODE_WIDTH   = 40,
  parameter int LEAF_ADDR    = 12,
  parameter int RULE_ID      = 14,
  parameter int RULE_WIDTH   = 160
) (
  input  logic                    clk,
  input  logic                    RST,
  input  logic [PACKET_WIDTH-1:0] packet_in1,
  input  logic                    data_valid_in1,
  input  logic [NODE_WIDTH-1:0]   node_in1,
  input  logic                    matched_in1,
  output logic [LEAF_ADDR-1:0]    rule_addr1,
  input  logic [RULE_WIDTH-1:0]   rule_data1,
  output logic                    valid_out1,
  output logic                    hit_out1,
  output logic [RULE_ID-1:0]      rule_id_out1,
  output logic [15:0]             hit_cnt1,
  input  logic [PACKET_WIDTH-1:0] packet_in2,
  input  logic                    data_valid_in2,
  input  logic [NODE_WIDTH-1:0]   node_in2,
  input  logic                    matched_in2,
  output logic [LEAF_ADDR-1:0]    rule_addr2,
  input  logic [RULE_WIDTH-1:0]   rule_data2,
  output logic                    valid_out2,
  output logic                    hit_out2,
  output logic [RULE_ID-1:0]      rule_id_out2,
  output logic [15:0]             hit_cnt2
);

  leaf_rule_match_lane #(
    .PACKET_WIDTH(PACKET_WIDTH), .NODE_WIDTH(NODE_WIDTH), .LEAF_ADDR(LEAF_ADDR),
    .RULE_ID(RULE_ID), .RULE_WIDTH(RULE_WIDTH)
  ) u_lane1 (
    .clk_i       (clk),
    .rst_i       (RST),
    .packet_i    (packet_in1),
    .valid_i     (data_valid_in1),
    .node_i      (node_in1),
    .matched_i   (matched_in1),
    .rule_addr_o (rule_addr1),
    .rule_data_i (rule_data1),
    .valid_o     (valid_out1),
    .hit_o       (hit_out1),
    .rule_id_o   (rule_id_out1),
    .hit_cnt_o   (hit_cnt1)
  );

  leaf_rule_match_lane #(
    .PACKET_WIDTH(PACKET_WIDTH), .NODE_WIDTH(NODE_WIDTH), .LEAF_ADDR(LEAF_ADDR),
    .RULE_ID(RULE_ID), .RULE_WIDTH(RULE_WIDTH)
  ) u_lane2 (
    .clk_i       (clk),
    .rst_i       (RST),
    .packet_i    (packet_in2),
    .valid_i     (data_valid_in2),
    .node_i      (node_in2),
    .matched_i   (matched_in2),
    .rule_addr_o (rule_addr2),
    .rule_data_i (rule_data2),
    .valid_o     (valid_out2),
    .hit_o       (hit_out2),
    .rule_id_o   (rule_id_out2),
    .hit_cnt_o   (hit_cnt2)
  );

endmodule

// File: doc/leaf_rule_match.md
LEAF_RULE_MATCH -- requirements
Module: leaf_rule_match

Interface
Parameters (name, default, meaning):
REQ-001 PACKET_WIDTH, 104, packet header width: [103:72] src IP, [71:40] dst IP, [39:24] src port, [23:8] dst port, [7:0] protocol.
REQ-002 NODE_WIDTH, 40, tree node width; leaf layout: [39:28] rule address, [27:14] rule ID.
REQ-003 LEAF_ADDR, 12, rule memory address width.
REQ-004 RULE_ID, 14, rule ID width.
REQ-005 RULE_WIDTH, 160, rule entry width: [159:128] src IP, [127:122] src prefix len, [121:90] dst IP, [89:84] dst prefix len, [83:68] src port lo, [67:52] src port hi, [51:36] dst port lo, [35:20] dst port hi, [19:12] protocol, [11] protocol wildcard, [10:0] reserved.

Ports (name, direction, width, meaning); the block has one clock, and reset is synchronous and active-high:
REQ-006 clk  in  1  clock.
REQ-007 RST  in  1  synchronous active-high reset.
REQ-008 For lane n in {1,2}:
- packet_in{n}  in  PACKET_WIDTH  packet header.
- data_valid_in{n}  in  1  input valid.
- node_in{n}  in  NODE_WIDTH  node from the last tree level.
- matched_in{n}  in  1  1 = node_in{n} is a leaf.
REQ-009 For lane n: rule_addr{n}  out  LEAF_ADDR  rule memory read address, combinational = node_in{n}[39:28].
REQ-010 For lane n: rule_data{n}  in  RULE_WIDTH  rule memory read data, valid exactly 2 cycles after the address.
REQ-011 For lane n: valid_out{n}  out  1  result valid.
REQ-012 For lane n: hit_out{n}  out  1  1 = packet matched the leaf rule.
REQ-013 For lane n: rule_id_out{n}  out  RULE_ID  matched rule ID; 0 when no hit.
REQ-014 For lane n: hit_cnt{n}  out  16  saturating count of hits.

Function
REQ-015 Each lane SHALL be an independent, fully pipelined path accepting one packet per cycle; the lanes SHALL have no shared state.
REQ-016 Latency SHALL be exactly 3 cycles.
- Inputs sampled at cycle T produce outputs registered at T+3.
- Cycles 1-2 delay packet, valid, matched and rule ID through two register stages, aligned with the memory latency.
- Cycle 3 compares and registers the result.
REQ-017 valid_out SHALL equal data_valid_in delayed by 3 cycles, independent of the match result.
REQ-018 hit_out SHALL be 1 only when all of the following hold for the delayed packet: valid = 1, matched = 1, and every field check below passes.
REQ-019 Prefix check, per IP: len = 0 always matches; len >= 32 requires exact equality; otherwise the top len bits of the packet IP SHALL equal the top len bits of the rule IP.
REQ-020 Port check, per port: lo <= port <= hi, inclusive and unsigned; lo > hi SHALL never match.
REQ-021 Protocol check: wildcard bit = 1 matches any protocol; otherwise exact 8-bit equality.
REQ-022 rule_id_out SHALL be the delayed node_in[27:14] when hit_out = 1, else 0.
REQ-023 When the delayed matched = 0 (non-leaf node reached the stage), the result SHALL be valid_out as delayed, hit_out = 0, rule_id_out = 0; rule_data SHALL be ignored.
REQ-024 hit_cnt SHALL increment by 1 on each cycle with valid_out = 1 and hit_out = 1 being registered, and SHALL hold at 16'hFFFF once reached (no wrap).
REQ-025 rule_addr SHALL be driven from node_in regardless of data_valid_in; the memory is read-only from this block.
REQ-026 Simultaneous valid traffic on both lanes SHALL be processed with no interaction or stall.

Reset
REQ-027 While RST = 1 at a clock edge, the following SHALL clear to 0: valid_out, hit_out, rule_id_out, hit_cnt, and all internal valid/matched pipeline bits.
- Packet and rule ID pipeline data need not clear.
REQ-028 Reset asserted mid-stream SHALL discard all in-flight packets: no valid_out = 1 in the 3 cycles after RST deasserts unless new valid input arrives.

Verification
REQ-029 Exact hit, lane 1:
- Stimulus: packet src 10.0.0.1, dst 192.168.1.5, sport 1000, dport 80, proto 6; leaf rule ID 0x123; rule 10.0.0.0/8, 192.168.1.0/24, sport 0-65535, dport 80-80, proto 6.
- Response at T+3: valid_out1 = 1, hit_out1 = 1, rule_id_out1 = 0x123, hit_cnt1 = 1.
REQ-030 Boundary miss: same stimulus with dport 81.
- Response at T+3: valid_out1 = 1, hit_out1 = 0, rule_id_out1 = 0; dport 80 and a wildcard proto with proto 17 both hit.
REQ-031 Non-leaf: matched_in2 = 0, valid = 1, rule_data2 forced to a matching rule.
- Response at T+3: valid_out2 = 1, hit_out2 = 0, rule_id_out2 = 0.
REQ-032 Back-to-back dual-lane stream: 8 consecutive valid packets per lane, alternating hit/miss.
- Response: outputs in order, 3-cycle latency, hit_cnt1 = hit_cnt2 = 4.
REQ-033 Saturation: preload 65534 hits, then send 3 more.
- Response: hit_cnt = 16'hFFFF, no wrap.
REQ-034 Mid-stream reset: RST = 1 for 1 cycle with 2 packets in flight.
- Response: all outputs 0 at the next edge, no stale valid_out afterwards, hit_cnt = 0.
